// File: rtl/lift_car_ctrl.sv
// Three-floor lift car controller: latches calls, SCAN scheduling, travel and door-dwell timing.
// Optional build macro LIFT_DOOR_HOLD_EN adds a door_hold input that freezes the door dwell timer.
module lift_car_ctrl #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] call,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic       m,
  output logic       f1,
  output logic       f2,
  output logic       f3,
  output logic [1:0] floor,
  output logic       dir,
  output logic [2:0] pending
);

  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] D_LAST = TW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [1:0]      floor_nx, arr_floor;
  logic            dir_nx, hold, m_nx;
  logic [2:0]      pending_nx, clr, f_nx;
  logic [2:0]      here, above, below, arr_mask, arr_above, arr_below;

  function automatic logic [2:0] mask_of(input logic [1:0] fl);
    case (fl)
      2'd1:    mask_of = 3'b001;
      2'd2:    mask_of = 3'b010;
      2'd3:    mask_of = 3'b100;
      default: mask_of = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] above_of(input logic [1:0] fl);
    case (fl)
      2'd1:    above_of = 3'b110;
      2'd2:    above_of = 3'b100;
      default: above_of = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_of(input logic [1:0] fl);
    case (fl)
      2'd2:    below_of = 3'b001;
      2'd3:    below_of = 3'b011;
      default: below_of = 3'b000;
    endcase
  endfunction

`ifdef LIFT_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  // Arrival masks describe the floor the car reaches at the end of the current crossing.
  assign arr_floor = dir ? floor + 2'd1 : floor - 2'd1;
  assign here      = mask_of(floor);
  assign above     = above_of(floor);
  assign below     = below_of(floor);
  assign arr_mask  = mask_of(arr_floor);
  assign arr_above = above_of(arr_floor);
  assign arr_below = below_of(arr_floor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      floor   <= 2'd1;
      dir     <= 1'b1;
      pending <= 3'b000;
      m       <= 1'b0;
      {f3, f2, f1} <= 3'b000;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      floor   <= floor_nx;
      dir     <= dir_nx;
      pending <= pending_nx;
      m       <= m_nx;
      {f3, f2, f1} <= f_nx;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    floor_nx = floor;
    dir_nx   = dir;
    clr      = 3'b000;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (|(pending & here)) begin
          state_nx = DOOR;
          clr      = here;
        end else if (|(pending & above) && (dir || !(|(pending & below)))) begin
          state_nx = MOVE;
          dir_nx   = 1'b1;
        end else if (|(pending & below)) begin
          state_nx = MOVE;
          dir_nx   = 1'b0;
        end
      end
      MOVE: begin
        if (timer == T_LAST) begin
          timer_nx = '0;
          floor_nx = arr_floor;
          if (|(pending & arr_mask)) begin
            state_nx = DOOR;
            clr      = arr_mask;
          end else if (!(|(pending & (dir ? arr_above : arr_below)))) begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      DOOR: begin
        if (|(call & here)) begin
          timer_nx = '0;
        end else if (!hold) begin
          if (timer == D_LAST) begin
            state_nx = IDLE;
            timer_nx = '0;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
    // A call for the floor being serviced extends the dwell instead of being queued.
    pending_nx = (pending | call) & ~clr & ~((state == DOOR) ? here : 3'b000);
  end

  always_comb begin
    m_nx = (state_nx == MOVE);
    f_nx = (state_nx == DOOR) ? mask_of(floor_nx) : 3'b000;
  end

endmodule

// File: tb/tb_lift_car_ctrl.sv
// Directed bench for lift_car_ctrl: expected output segments (state tuple + length) are queued
// by the stimulus and checked by a negedge monitor that splits the outputs into constant runs.
module tb_lift_car_ctrl;
  localparam int W = 14;
`ifdef LIFT_DOOR_HOLD_EN
  localparam int HOLD_LEN = 14;
`else
  localparam int HOLD_LEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] call = 3'b000;
  logic       door_hold = 1'b0;
  logic       m, f1, f2, f3, dir;
  logic [1:0] floor;
  logic [2:0] pending;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  lift_car_ctrl #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .call(call),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .m(m), .f1(f1), .f2(f2), .f3(f3), .floor(floor), .dir(dir), .pending(pending)
  );

  // Segment encoding: {m, f3 f2 f1, floor, length}; length 0 means any length.
  function automatic logic [W-1:0] seg(input logic mm, input logic [2:0] ff,
                                       input logic [1:0] fl, input int len);
    seg = {mm, ff, fl, 8'(len)};
  endfunction

  task automatic push(input logic [W-1:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic [5:0] t, input int len);
    logic [W-1:0] e;
    vec_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL segment: unexpected m=%b f=%b floor=%0d len=%0d", t[5], t[4:2], t[1:0], len);
    end else begin
      e = exp_q.pop_front();
      if (t !== e[13:8] || (e[7:0] != 8'd0 && len != int'(e[7:0]))) begin
        err_cnt++;
        $display("FAIL segment: got m=%b f=%b floor=%0d len=%0d expected m=%b f=%b floor=%0d len=%0d",
                 t[5], t[4:2], t[1:0], len, e[13], e[12:10], e[9:8], e[7:0]);
      end
    end
  endtask

  logic [5:0] prev_t;
  int         run_len = 0;
  logic       mon_started = 1'b0;

  always @(negedge clk) begin : monitor
    logic [5:0] cur_t;
    cur_t = {m, f3, f2, f1, floor};
    if (mon_started && cur_t !== prev_t) begin
      sb_pop(prev_t, run_len);
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_t = cur_t;
    mon_started = 1'b1;
  end

  function automatic logic pick(input int sel);
    case (sel)
      0:       pick = m;
      1:       pick = f1;
      2:       pick = f2;
      3:       pick = f3;
      default: pick = m && (floor == 2'd2);
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val, input int budget);
    int   n;
    logic s;
    n = 0;
    do begin
      @(negedge clk);
      s = pick(sel);
      n++;
    end while (s !== val && n < budget);
    if (s !== val) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL timeout %s: got %b expected %b within %0d clocks", name, s, val, budget);
    end
  endtask

  task automatic pulse_call(input logic [2:0] c);
    call = c;
    @(negedge clk);
    call = 3'b000;
  endtask

  task automatic rehome();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a move
    push(seg(0, 3'b000, 1, 0));
    push(seg(1, 3'b000, 1, 0));
    pulse_call(3'b100);
    wait_sig("move_start", 0, 1'b1, 10);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_m", {7'd0, m}, 8'd0);
    check("rst_f", {5'd0, f3, f2, f1}, 8'd0);
    check("rst_floor", {6'd0, floor}, 8'd1);
    check("rst_dir", {7'd0, dir}, 8'd1);
    check("rst_pending", {5'd0, pending}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_m", {7'd0, m}, 8'd0);
    check("idle_pending", {5'd0, pending}, 8'd0);

    // Floor 1 to floor 3 non-stop
    push(seg(0, 3'b000, 1, 0));
    push(seg(1, 3'b000, 1, 8));
    push(seg(1, 3'b000, 2, 8));
    push(seg(0, 3'b100, 3, 4));
    pulse_call(3'b100);
    wait_sig("b_f3_on", 3, 1'b1, 40);
    wait_sig("b_f3_off", 3, 1'b0, 20);
    repeat (3) @(negedge clk);
    check("b_pending", {5'd0, pending}, 8'd0);
    check("b_floor", {6'd0, floor}, 8'd3);
    push(seg(0, 3'b000, 3, 0));
    rehome();

    // Door at current floor, restarted after the first dwell clock
    push(seg(0, 3'b000, 1, 0));
    push(seg(0, 3'b001, 1, 5));
    pulse_call(3'b001);
    wait_sig("c_f1_on", 1, 1'b1, 10);
    pulse_call(3'b001);
    wait_sig("c_f1_off", 1, 1'b0, 20);
    check("c_pending", {5'd0, pending}, 8'd0);

    // Intermediate stop at floor 2 on the way to floor 3
    push(seg(0, 3'b000, 1, 0));
    push(seg(1, 3'b000, 1, 8));
    push(seg(0, 3'b010, 2, 4));
    push(seg(0, 3'b000, 2, 1));
    push(seg(1, 3'b000, 2, 8));
    push(seg(0, 3'b100, 3, 4));
    pulse_call(3'b100);
    wait_sig("d_move", 0, 1'b1, 10);
    repeat (2) @(negedge clk);
    pulse_call(3'b010);
    wait_sig("d_f3_on", 3, 1'b1, 60);
    wait_sig("d_f3_off", 3, 1'b0, 20);
    push(seg(0, 3'b000, 3, 0));
    rehome();

    // SCAN: keep going up to 3, then sweep down to 1
    push(seg(0, 3'b000, 1, 0));
    push(seg(1, 3'b000, 1, 8));
    push(seg(1, 3'b000, 2, 8));
    push(seg(0, 3'b100, 3, 4));
    push(seg(0, 3'b000, 3, 1));
    push(seg(1, 3'b000, 3, 8));
    push(seg(1, 3'b000, 2, 8));
    push(seg(0, 3'b001, 1, 4));
    pulse_call(3'b100);
    wait_sig("e_at2", 4, 1'b1, 30);
    pulse_call(3'b001);
    wait_sig("e_f1_on", 1, 1'b1, 80);
    check("e_dir", {7'd0, dir}, 8'd0);
    wait_sig("e_f1_off", 1, 1'b0, 20);

    // Door hold during the floor-3 dwell
    push(seg(0, 3'b000, 1, 0));
    push(seg(1, 3'b000, 1, 8));
    push(seg(1, 3'b000, 2, 8));
    push(seg(0, 3'b100, 3, HOLD_LEN));
    pulse_call(3'b100);
    wait_sig("f_f3_on", 3, 1'b1, 40);
    door_hold = 1'b1;
    repeat (10) @(negedge clk);
    door_hold = 1'b0;
    wait_sig("f_f3_off", 3, 1'b0, 20);
    repeat (5) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
